// File: rtl/lsu_pipe.sv
// Load/store unit front end: accepts one request at a time, drives a single SRAM
// access, waits (with timeout) for completion and returns aligned/extended load data.
module lsu_pipe #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W-1:0]     rt_value,
    input  logic [1:0]            mem_type,
    input  logic [2:0]            mem_size,
    input  logic                  mem_signed,
    output logic                  mem_en,
    output logic [DATA_W/8-1:0]   mem_wen,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_rvalid,
    output logic [DATA_W-1:0]     result,
    output logic                  result_valid,
    output logic                  address_error,
    output logic                  timeout_error,
    output logic                  busy
);

    localparam int NB  = DATA_W / 8;
    localparam int OFF = $clog2(NB);
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t             state;
    logic [ADDR_W-1:0]  addr_reg;
    logic [2:0]         size_reg;
    logic               signed_reg;
    logic [1:0]         type_reg;
    logic [15:0]        cnt;

    logic               req_is_ls;
    logic               req_is_store;
    logic               misaligned;
    logic [4:0]         req_bytes;
    logic [4:0]         lane_lo;
    logic [4:0]         lane_hi;
    logic [NB-1:0]      wen_calc;
    logic [DATA_W-1:0]  wdata_calc;
    logic [DATA_W-1:0]  rd_shift;
    logic [DATA_W-1:0]  load_val;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // Request decode: access size and alignment legality
    always_comb begin
        req_is_ls    = (mem_type == 2'b01) || (mem_type == 2'b10);
        req_is_store = (mem_type == 2'b10);
        case (mem_size)
            3'b000: begin req_bytes = 5'd1; misaligned = 1'b0;                               end
            3'b001: begin req_bytes = 5'd2; misaligned = address[0];                         end
            3'b010: begin req_bytes = 5'd4; misaligned = |address[1:0];                      end
            3'b011: begin req_bytes = 5'd8; misaligned = (DATA_W == 32) || (|address[2:0]); end
            default: begin req_bytes = 5'd0; misaligned = 1'b1;                              end
        endcase
    end

    assign lane_lo = 5'(address[OFF-1:0]);
    assign lane_hi = lane_lo + req_bytes;

    // Per-lane enable and replicated store data; an aligned access therefore
    // always finds the low bytes of rt_value on its own lanes.
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        assign wen_calc[gi] = (5'(gi) >= lane_lo) && (5'(gi) < lane_hi);
        assign wdata_calc[8*gi +: 8] =
            (mem_size[1:0] == 2'b00) ? rt_value[7:0] :
            (mem_size[1:0] == 2'b01) ? rt_value[8*(gi % 2) +: 8] :
            (mem_size[1:0] == 2'b10) ? rt_value[8*(gi % 4) +: 8] :
                                       rt_value[8*gi +: 8];
    end

    assign rd_shift = mem_rdata >> {addr_reg[OFF-1:0], 3'b000};

    always_comb begin
        load_val = rd_shift;
        case (size_reg[1:0])
            2'b00:   for (int i = 8;  i < DATA_W; i++) load_val[i] = signed_reg & rd_shift[7];
            2'b01:   for (int i = 16; i < DATA_W; i++) load_val[i] = signed_reg & rd_shift[15];
            2'b10:   for (int i = 32; i < DATA_W; i++) load_val[i] = signed_reg & rd_shift[31];
            default: load_val = rd_shift;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            addr_reg      <= '0;
            size_reg      <= '0;
            signed_reg    <= 1'b0;
            type_reg      <= '0;
            cnt           <= '0;
            mem_en        <= 1'b0;
            mem_wen       <= '0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            result        <= '0;
            result_valid  <= 1'b0;
            address_error <= 1'b0;
            timeout_error <= 1'b0;
        end else begin
            mem_en        <= 1'b0;
            mem_wen       <= '0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            result_valid  <= 1'b0;
            address_error <= 1'b0;
            timeout_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_reg   <= address;
                        size_reg   <= mem_size;
                        signed_reg <= mem_signed;
                        type_reg   <= mem_type;
                        cnt        <= '0;
                        if (!req_is_ls) begin
                            state        <= RESP;
                            result_valid <= 1'b1;
                            result       <= DATA_W'(address);
                        end else if (misaligned) begin
                            state         <= RESP;
                            result_valid  <= 1'b1;
                            address_error <= 1'b1;
                            result        <= req_is_store ? DATA_W'(address) : '0;
                        end else begin
                            state     <= ACCESS;
                            mem_en    <= 1'b1;
                            mem_addr  <= {address[ADDR_W-1:OFF], {OFF{1'b0}}};
                            mem_wen   <= req_is_store ? wen_calc : '0;
                            mem_wdata <= req_is_store ? wdata_calc : '0;
                        end
                    end
                end
                ACCESS: state <= WAIT;
                WAIT: begin
                    // A completion on the last counted cycle wins over the timeout
                    if (mem_rvalid) begin
                        state        <= RESP;
                        result_valid <= 1'b1;
                        result       <= (type_reg == 2'b01) ? load_val : DATA_W'(addr_reg);
                    end else if (cnt == CNT_LAST) begin
                        state         <= RESP;
                        result_valid  <= 1'b1;
                        timeout_error <= 1'b1;
                        result        <= (type_reg == 2'b01) ? '0 : DATA_W'(addr_reg);
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/lsu_pipe.md
LSU_PIPE -- requirements
Module: lsu_pipe

Interface
REQ-001 Parameters SHALL be: DATA_W, default 32, data width (32 or 64 only); ADDR_W, default 32, address width; TIMEOUT, default 255, maximum wait cycles for mem_rvalid (1..65535).
REQ-002 Derived constants SHALL be: NB = DATA_W/8 byte lanes; OFF = log2(NB) address offset bits.
REQ-003 Ports SHALL be, in order:
  clk  in  1  clock, all state on rising edge
  rst  in  1  asynchronous, active-high reset
  req_valid  in  1  request present
  req_ready  out  1  request accepted when req_valid & req_ready
  address  in  ADDR_W  byte address
  rt_value  in  DATA_W  store data, right-aligned
  mem_type  in  2  00 noop, 01 load, 10 store, 11 reserved (treated as noop)
  mem_size  in  3  000 byte, 001 half, 010 word, 011 dword; others reserved
  mem_signed  in  1  1 = sign-extend load, 0 = zero-extend
  mem_en  out  1  SRAM access strobe
  mem_wen  out  NB  per-lane write enable
  mem_addr  out  ADDR_W  address with low OFF bits forced to 0
  mem_wdata  out  DATA_W  lane-shifted store data
  mem_rdata  in  DATA_W  read data, valid with mem_rvalid
  mem_rvalid  in  1  SRAM completion, for loads and stores
  result  out  DATA_W  load data, or address for store/noop
  result_valid  out  1  one-cycle completion pulse
  address_error  out  1  misalignment or illegal size, held with result_valid
  timeout_error  out  1  no mem_rvalid within TIMEOUT cycles, held with result_valid
  busy  out  1  operation in flight

Function
REQ-010 FSM SHALL have states IDLE, ACCESS, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-011 On handshake in IDLE, all request fields SHALL be registered and the next state SHALL be ACCESS for load/store, or RESP for noop/reserved type.
REQ-012 Alignment check at acceptance: half errors if address[0]=1; word errors if address[1:0]!=0; dword errors if address[2:0]!=0; dword with DATA_W=32 or any reserved size SHALL error.
REQ-013 An erroring request SHALL go directly to RESP with mem_en=0 and mem_wen=0 on every cycle, and address_error=1.
REQ-014 ACCESS SHALL last exactly one cycle with mem_en=1, mem_addr, mem_wen and mem_wdata driven; then WAIT.
REQ-015 Store mem_wen SHALL be 1s on lanes [lane, lane+bytes-1], where lane = address[OFF-1:0] and bytes = 1/2/4/8; load mem_wen SHALL be 0.
REQ-016 mem_wdata SHALL be rt_value replicated across lanes so that the addressed lanes carry the low bytes of rt_value.
REQ-017 In WAIT, mem_en SHALL be 0 and a cycle counter SHALL increment; mem_rvalid=1 SHALL capture mem_rdata (loads) and go to RESP.
REQ-018 If the counter reaches TIMEOUT without mem_rvalid, the FSM SHALL go to RESP with timeout_error=1 and result=0 for loads.
REQ-019 mem_rvalid in the same cycle the counter reaches TIMEOUT SHALL count as success, with no timeout.
REQ-020 mem_rvalid outside WAIT SHALL be ignored.
REQ-021 Load result SHALL select bytes from lane "lane" and sign-extend when mem_signed=1 or zero-extend when mem_signed=0; word or dword at full width SHALL pass through unchanged.
REQ-022 Store and noop result SHALL be the registered address, zero-extended to DATA_W.
REQ-023 RESP SHALL last one cycle with result_valid=1 and errors valid; then IDLE, so that req_ready=1 in the next cycle.
REQ-024 result SHALL hold its value until the next RESP; address_error and timeout_error SHALL be 0 outside RESP.
REQ-025 busy SHALL equal (state != IDLE).
REQ-026 Minimum latency: a load or store accepted at cycle N with mem_rvalid at N+2 gives result_valid at N+3; a noop gives result_valid at N+1.

Reset
REQ-030 While rst=1, the block SHALL be in state IDLE, the counter and all captured registers SHALL be 0, and all outputs SHALL be 0 except req_ready=1.
REQ-031 rst asserted mid-operation SHALL abort the operation immediately, with no result_valid generated for the aborted operation.

Verification
REQ-040 DATA_W=32, signed byte load at address 0x1003, mem_rdata=0x80FF_FF12 at WAIT cycle 1 -> mem_wen=0000, mem_addr=0x1000, result=0xFFFF_FF80, result_valid at acceptance+3.
REQ-041 DATA_W=32, half store of rt_value 0xABCD at address 0x2002 -> mem_wen=1100, mem_wdata[31:16]=0xABCD, result=0x2002.
REQ-042 Word load at address 0x0001 -> no mem_en pulse, address_error=1 with result_valid at acceptance+1.
REQ-043 TIMEOUT=4 with mem_rvalid never asserted -> timeout_error=1, result=0 with result_valid at acceptance+6; then req_ready=1.
REQ-044 DATA_W=64, unsigned dword load at address 0x8 -> mem_wen=0x00, full mem_rdata passed to result; same request with DATA_W=32 -> address_error=1.
REQ-045 rst pulsed during WAIT, then mem_rvalid -> no result_valid; outputs at reset values; next request completes normally.
